mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Parametrised memory-access pipeline stage between execute and write-back. Accepts one operation at a time and issues it on a request/acknowledge memory port that tolerates wait states. Supports full-word, byte and signed-byte loads, full-word and byte stores, and LL/SC with an internally held link bit. Produces a registered write-back record and stalls upstream while a memory access is outstanding.

## Interface
Parameters:
- DATA_W, 32, data width; a multiple of 8; DATA_W/8 is a power of two.
- ADDR_W, 32, memory address width.
- RADDR_W, 5, register-file address width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operation presented.
- in_ready  out  1  stage can accept; high only in IDLE.
- ls_op  in  3  operation: 0 NONE, 1 LW, 2 SW, 3 LB, 4 LBU, 5 SB, 6 LL, 7 SC.
- addr  in  ADDR_W  effective address.
- st_data  in  DATA_W  store data.
- rd_addr  in  RADDR_W  destination register.
- rd_wr  in  1  destination write enable.
- alu_data  in  DATA_W  result for the NONE op.
- flush  in  1  exception or ERET; clears the link bit and squashes write-back.
- mem_req / mem_we  out  1 / 1  access request / write.
- mem_addr  out  ADDR_W  access address.
- mem_wdata  out  DATA_W  write data, lane-replicated.
- mem_be  out  DATA_W/8  byte enables.
- mem_ack  in  1  access complete; mem_rdata is valid in the same cycle.
- mem_rdata  in  DATA_W  read data.
- wb_valid / wb_wr  out  1 / 1  write-back record valid / register write.
- wb_addr / wb_data  out  RADDR_W / DATA_W  write-back destination / value.
- llbit  out  1  current link bit.
- misalign  out  1  alignment fault; present only when the configuration macro is defined.

## Operation
- FSM states: IDLE and WAIT.
- IDLE, in_valid && op NONE:
  - Register wb_* from alu_data, rd_addr and rd_wr.
  - Stay in IDLE.
- IDLE, in_valid && memory op:
  - Drive mem_* from the registered request and go to WAIT.
  - Exception: SC with llbit==0 performs no access. It writes back 0 in 1 cycle and stays in IDLE.
- WAIT: hold mem_req and all mem_* signals stable until mem_ack. On ack, register wb_* and return to IDLE.
- Write-back value for a successful SC is 1.
- Byte lane: lane = addr[log2(DATA_W/8)-1:0], little-endian.
  - LB sign-extends the lane byte to DATA_W.
  - LBU zero-extends it.
  - SB sets mem_be = one-hot(lane) and replicates the byte across mem_wdata.
  - LW, SW, LL and SC use full width, with mem_be all ones. Address low lane bits are forced to 0.
- Link bit:
  - Set on an LL ack.
  - Cleared by an SC ack, by flush and by rst.
  - An SC issued with llbit==1 performs the store.
- Flush:
  - In IDLE, the accepted op is discarded and there is no wb_valid.
  - In WAIT, the outstanding access still completes. wb_valid is suppressed and the LL set is cancelled.
  - If flush coincides with an LL ack, llbit ends at 0.
- Reset mid-WAIT: return to IDLE and drop mem_req. The memory side discards the request.

## Timing
- Reset values:
  - State IDLE; llbit 0; misalign 0.
  - wb_valid, wb_wr, mem_req and mem_we are 0.
  - mem_addr, mem_wdata, mem_be, wb_addr and wb_data are 0.
- Latency:
  - NONE and failed SC: wb_valid 1 cycle after acceptance.
  - Memory ops: mem_req asserts the cycle after acceptance. wb_valid asserts the cycle after mem_ack.
  - With a zero-wait memory, latency is 2 cycles.
- in_ready is 0 from acceptance of a memory op until the cycle after mem_ack.
- wb_valid is a 1-cycle pulse per accepted op.
- mem_ack outside WAIT is ignored.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - A full-width op with nonzero lane bits raises misalign for 1 cycle, at the cycle wb_valid would occur.
  - No memory request is made and there is no write-back.
  - llbit is unchanged.
- MEM_ALIGN_CHECK_EN undefined:
  - The misalign port is absent.
  - Lane bits are silently forced to 0.

## Test plan
- LW addr 0x100, memory returns 0xDEADBEEF after 3 wait cycles -> mem_req high for 4 cycles; wb_data 0xDEADBEEF 1 cycle after ack; in_ready low throughout.
- LB addr 0x103, rdata 0x80AABBCC -> wb_data 0xFFFFFF80. LBU at the same address -> 0x00000080.
- SB addr 0x102, st_data 0x5A -> mem_be 4'b0100, mem_wdata 0x5A5A5A5A, mem_we 1.
- LL 0x200, then SC 0x200 -> llbit 1 after LL; SC stores and writes back 1; llbit 0 afterwards. A second SC -> no mem_req, wb_data 0.
- LL in WAIT with flush asserted on the ack cycle -> llbit 0, no wb_valid, FSM back to IDLE.
- With MEM_ALIGN_CHECK_EN, SW addr 0x102 -> misalign pulse, no mem_req. Without the macro -> store to 0x100 with mem_be 4'b1111.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-access stage between execute and write-back.
// Takes one operation at a time and issues it on a req/ack memory port that
// may insert wait states. Handles LW/SW, LB/LBU/SB and LL/SC with a
// locally held link bit, and produces a registered write-back record.
// Optional feature macro: MEM_ALIGN_CHECK_EN. When it is defined, a
// full-width op with nonzero lane bits raises the misalign port and makes no
// access. When it is undefined, the misalign port is absent and the lane
// bits of full-width ops are forced to zero.
// Assumes DATA_W >= 16, so that at least one lane-select address bit exists.

module mem_access_unit #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int RADDR_W = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2:0]           ls_op,
   input  logic [ADDR_W-1:0]    addr,
   input  logic [DATA_W-1:0]    st_data,
   input  logic [RADDR_W-1:0]   rd_addr,
   input  logic                 rd_wr,
   input  logic [DATA_W-1:0]    alu_data,
   input  logic                 flush,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [DATA_W-1:0]    mem_wdata,
   output logic [DATA_W/8-1:0]  mem_be,
   input  logic                 mem_ack,
   input  logic [DATA_W-1:0]    mem_rdata,
   output logic                 llbit,
`ifdef MEM_ALIGN_CHECK_EN
   output logic                 misalign,
`endif
   output logic                 wb_valid,
   output logic                 wb_wr,
   output logic [RADDR_W-1:0]   wb_addr,
   output logic [DATA_W-1:0]    wb_data
);

   localparam int BE_W   = DATA_W / 8;
   localparam int LANE_W = $clog2(BE_W);

   typedef enum logic [2:0] {
      OP_NONE = 3'd0,
      OP_LW   = 3'd1,
      OP_SW   = 3'd2,
      OP_LB   = 3'd3,
      OP_LBU  = 3'd4,
      OP_SB   = 3'd5,
      OP_LL   = 3'd6,
      OP_SC   = 3'd7
   } lsOp_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_e;

   state_e               state_q;
   lsOp_e                op_q;
   logic [LANE_W-1:0]    lane_q;
   logic [RADDR_W-1:0]   rdAddr_q;
   logic                 rdWr_q;
   logic                 squash_q;
   logic                 memReq_q;
   logic                 memWe_q;
   logic [ADDR_W-1:0]    memAddr_q;
   logic [DATA_W-1:0]    memWdata_q;
   logic [BE_W-1:0]      memBe_q;
   logic                 wbValid_q;
   logic                 wbWr_q;
   logic [RADDR_W-1:0]   wbAddr_q;
   logic [DATA_W-1:0]    wbData_q;
   logic                 llBit_q;
`ifdef MEM_ALIGN_CHECK_EN
   logic                 misalign_q;
`endif

   lsOp_e                reqOp;
   logic [LANE_W-1:0]    reqLane;
   logic                 reqFull;
   logic                 reqStore;
   logic                 reqMisalign;
   logic [ADDR_W-1:0]    reqAddr;
   logic [BE_W-1:0]      reqBe;
   logic [DATA_W-1:0]    reqWdata;
   logic [7:0]           ackByte;
   logic [DATA_W-1:0]    ackData;
   logic                 ackSquash;

   // Decode the incoming operation into the memory request it would issue:
   // full-width ops get an aligned address and all byte enables, byte
   // stores get a one-hot enable and the byte replicated on every lane.
   always_comb begin
      reqOp       = lsOp_e'(ls_op);
      reqLane     = addr[LANE_W-1:0];
      reqFull     = 1'b0;
      reqStore    = 1'b0;
      reqMisalign = 1'b0;
      reqAddr     = addr;
      reqBe       = BE_W'(1) << reqLane;
      reqWdata    = {BE_W{st_data[7:0]}};
      case (reqOp)
         OP_LW, OP_LL: reqFull = 1'b1;
         OP_SW, OP_SC: begin
            reqFull  = 1'b1;
            reqStore = 1'b1;
         end
         OP_SB:   reqStore = 1'b1;
         default: reqFull = 1'b0;
      endcase
      if (reqFull) begin
         reqAddr  = {addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
         reqBe    = {BE_W{1'b1}};
         reqWdata = st_data;
`ifdef MEM_ALIGN_CHECK_EN
         reqMisalign = (reqLane != '0);
`endif
      end
   end

   // Shape the returned read data into the write-back value for the
   // outstanding op; a completed SC reports success as 1, and a flush seen
   // at any point during the wait squashes the write-back.
   always_comb begin
      ackByte   = mem_rdata[{lane_q, 3'b000} +: 8];
      ackData   = '0;
      ackSquash = flush | squash_q;
      case (op_q)
         OP_LW, OP_LL: ackData = mem_rdata;
         OP_LB:        ackData = {{(DATA_W-8){ackByte[7]}}, ackByte};
         OP_LBU:       ackData = {{(DATA_W-8){1'b0}}, ackByte};
         OP_SC:        ackData = DATA_W'(1);
         default:      ackData = '0;
      endcase
   end

   // Main controller: accepts ops in IDLE, holds the memory request stable
   // in WAIT until ack, and maintains the link bit and write-back record.
   // wb_valid and misalign are single-cycle pulses, so they default low.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         op_q       <= OP_NONE;
         lane_q     <= '0;
         rdAddr_q   <= '0;
         rdWr_q     <= 1'b0;
         squash_q   <= 1'b0;
         memReq_q   <= 1'b0;
         memWe_q    <= 1'b0;
         memAddr_q  <= '0;
         memWdata_q <= '0;
         memBe_q    <= '0;
         wbValid_q  <= 1'b0;
         wbWr_q     <= 1'b0;
         wbAddr_q   <= '0;
         wbData_q   <= '0;
         llBit_q    <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
         misalign_q <= 1'b0;
`endif
      end else begin
         wbValid_q <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
         misalign_q <= 1'b0;
`endif
         if (flush) begin
            llBit_q <= 1'b0;
         end
         case (state_q)
            S_IDLE: begin
               if (in_valid && !flush) begin
                  if (reqOp == OP_NONE) begin
                     wbValid_q <= 1'b1;
                     wbWr_q    <= rd_wr;
                     wbAddr_q  <= rd_addr;
                     wbData_q  <= alu_data;
                  end else if (reqMisalign) begin
`ifdef MEM_ALIGN_CHECK_EN
                     misalign_q <= 1'b1;
`endif
                  end else if (reqOp == OP_SC && !llBit_q) begin
                     wbValid_q <= 1'b1;
                     wbWr_q    <= rd_wr;
                     wbAddr_q  <= rd_addr;
                     wbData_q  <= '0;
                  end else begin
                     memReq_q   <= 1'b1;
                     memWe_q    <= reqStore;
                     memAddr_q  <= reqAddr;
                     memBe_q    <= reqBe;
                     memWdata_q <= reqWdata;
                     op_q       <= reqOp;
                     lane_q     <= reqLane;
                     rdAddr_q   <= rd_addr;
                     rdWr_q     <= rd_wr;
                     squash_q   <= 1'b0;
                     state_q    <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (flush) begin
                  squash_q <= 1'b1;
               end
               if (mem_ack) begin
                  memReq_q <= 1'b0;
                  memWe_q  <= 1'b0;
                  state_q  <= S_IDLE;
                  if (!ackSquash) begin
                     wbValid_q <= 1'b1;
                     wbWr_q    <= rdWr_q;
                     wbAddr_q  <= rdAddr_q;
                     wbData_q  <= ackData;
                  end
                  if (op_q == OP_LL) begin
                     llBit_q <= !ackSquash;
                  end else if (op_q == OP_SC) begin
                     llBit_q <= 1'b0;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign mem_req   = memReq_q;
   assign mem_we    = memWe_q;
   assign mem_addr  = memAddr_q;
   assign mem_wdata = memWdata_q;
   assign mem_be    = memBe_q;
   assign wb_valid  = wbValid_q;
   assign wb_wr     = wbWr_q;
   assign wb_addr   = wbAddr_q;
   assign wb_data   = wbData_q;
   assign llbit     = llBit_q;
`ifdef MEM_ALIGN_CHECK_EN
   assign misalign  = misalign_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit
// (default 32-bit data, 32-bit address, 5-bit register address). The memory
// side is driven by hand from the stimulus sequence. Follows the
// MEM_ALIGN_CHECK_EN macro so it matches whichever build it is compiled with.

module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  ls_op;
   logic [31:0] addr;
   logic [31:0] st_data;
   logic [4:0]  rd_addr;
   logic        rd_wr;
   logic [31:0] alu_data;
   logic        flush;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        llbit;
`ifdef MEM_ALIGN_CHECK_EN
   logic        misalign;
`endif
   logic        wb_valid;
   logic        wb_wr;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;

   int checks   = 0;
   int failures = 0;

   mem_access_unit #(.DATA_W(32), .ADDR_W(32), .RADDR_W(5)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .ls_op(ls_op),
      .addr(addr), .st_data(st_data), .rd_addr(rd_addr), .rd_wr(rd_wr),
      .alu_data(alu_data), .flush(flush),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .llbit(llbit),
`ifdef MEM_ALIGN_CHECK_EN
      .misalign(misalign),
`endif
      .wb_valid(wb_valid), .wb_wr(wb_wr), .wb_addr(wb_addr), .wb_data(wb_data)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Advance one rising edge and settle 1 unit past it before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Present one operation for a single accepting edge, then withdraw it.
   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] sd, input logic [4:0] rd,
                                input logic wr, input logic [31:0] alu);
      in_valid = 1'b1;
      ls_op    = op;
      addr     = a;
      st_data  = sd;
      rd_addr  = rd;
      rd_wr    = wr;
      alu_data = alu;
      tick();
      in_valid = 1'b0;
      ls_op    = 3'd0;
   endtask

   // Memory answers in the current cycle with the given read data.
   task automatic memAck(input logic [31:0] rdata);
      mem_ack   = 1'b1;
      mem_rdata = rdata;
      tick();
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; ls_op = 3'd0; addr = '0; st_data = '0;
      rd_addr = '0; rd_wr = 1'b0; alu_data = '0; flush = 1'b0;
      mem_ack = 1'b0; mem_rdata = '0;
      tick();
      tick();
      checkOutput("rst_in_ready", in_ready, 1);
      checkOutput("rst_mem_req", mem_req, 0);
      checkOutput("rst_mem_addr", mem_addr, 0);
      checkOutput("rst_mem_be", mem_be, 0);
      checkOutput("rst_wb_valid", wb_valid, 0);
      checkOutput("rst_wb_data", wb_data, 0);
      checkOutput("rst_llbit", llbit, 0);
`ifdef MEM_ALIGN_CHECK_EN
      checkOutput("rst_misalign", misalign, 0);
`endif
      rst = 1'b0;
      tick();

      // NONE op: ALU result written back one cycle after acceptance.
      applyStimulus(3'd0, 32'h0, 32'h0, 5'd3, 1'b1, 32'h12345678);
      checkOutput("none_wb_valid", wb_valid, 1);
      checkOutput("none_wb_data", wb_data, 32'h12345678);
      checkOutput("none_wb_addr", wb_addr, 3);
      checkOutput("none_wb_wr", wb_wr, 1);
      checkOutput("none_mem_req", mem_req, 0);
      tick();
      checkOutput("none_wb_pulse", wb_valid, 0);

      // Stray ack in IDLE has no effect.
      memAck(32'hFFFFFFFF);
      checkOutput("idle_ack_wb_valid", wb_valid, 0);
      checkOutput("idle_ack_in_ready", in_ready, 1);

      // LW 0x100 with three wait cycles: request high for four cycles.
      applyStimulus(3'd1, 32'h100, 32'h0, 5'd4, 1'b1, 32'h0);
      for (int i = 0; i < 4; i++) begin
         checkOutput("lw_mem_req", mem_req, 1);
         checkOutput("lw_in_ready", in_ready, 0);
         checkOutput("lw_mem_addr", mem_addr, 32'h100);
         checkOutput("lw_wb_valid_early", wb_valid, 0);
         if (i < 3) tick();
      end
      checkOutput("lw_mem_we", mem_we, 0);
      checkOutput("lw_mem_be", mem_be, 4'hF);
      memAck(32'hDEADBEEF);
      checkOutput("lw_wb_valid", wb_valid, 1);
      checkOutput("lw_wb_data", wb_data, 32'hDEADBEEF);
      checkOutput("lw_wb_addr", wb_addr, 4);
      checkOutput("lw_mem_req_drop", mem_req, 0);
      checkOutput("lw_in_ready_back", in_ready, 1);

      // LB / LBU on lane 3.
      applyStimulus(3'd3, 32'h103, 32'h0, 5'd7, 1'b1, 32'h0);
      checkOutput("lb_mem_addr", mem_addr, 32'h103);
      memAck(32'h80AABBCC);
      checkOutput("lb_wb_data", wb_data, 32'hFFFFFF80);
      applyStimulus(3'd4, 32'h103, 32'h0, 5'd7, 1'b1, 32'h0);
      memAck(32'h80AABBCC);
      checkOutput("lbu_wb_data", wb_data, 32'h00000080);
      applyStimulus(3'd4, 32'h101, 32'h0, 5'd7, 1'b1, 32'h0);
      memAck(32'h80AABBCC);
      checkOutput("lbu_lane1_wb_data", wb_data, 32'h000000BB);

      // SB to lane 2: one-hot enable and low byte replicated.
      applyStimulus(3'd5, 32'h102, 32'h1234565A, 5'd0, 1'b0, 32'h0);
      checkOutput("sb_mem_be", mem_be, 4'b0100);
      checkOutput("sb_mem_wdata", mem_wdata, 32'h5A5A5A5A);
      checkOutput("sb_mem_we", mem_we, 1);
      checkOutput("sb_mem_addr", mem_addr, 32'h102);
      memAck(32'h0);
      checkOutput("sb_wb_valid", wb_valid, 1);

      // LL then SC succeeds; a second SC fails without an access.
      applyStimulus(3'd6, 32'h200, 32'h0, 5'd5, 1'b1, 32'h0);
      memAck(32'h00000077);
      checkOutput("ll_llbit", llbit, 1);
      checkOutput("ll_wb_data", wb_data, 32'h77);
      applyStimulus(3'd7, 32'h200, 32'h0000CAFE, 5'd6, 1'b1, 32'h0);
      checkOutput("sc_mem_req", mem_req, 1);
      checkOutput("sc_mem_we", mem_we, 1);
      checkOutput("sc_mem_be", mem_be, 4'hF);
      checkOutput("sc_mem_wdata", mem_wdata, 32'h0000CAFE);
      memAck(32'h0);
      checkOutput("sc_wb_data", wb_data, 1);
      checkOutput("sc_wb_valid", wb_valid, 1);
      checkOutput("sc_llbit_clear", llbit, 0);
      applyStimulus(3'd7, 32'h200, 32'h0000BEEF, 5'd6, 1'b1, 32'h0);
      checkOutput("sc2_mem_req", mem_req, 0);
      checkOutput("sc2_wb_valid", wb_valid, 1);
      checkOutput("sc2_wb_data", wb_data, 0);
      checkOutput("sc2_in_ready", in_ready, 1);

      // LL with flush on the ack cycle: no link, no write-back.
      applyStimulus(3'd6, 32'h200, 32'h0, 5'd5, 1'b1, 32'h0);
      checkOutput("llf_mem_req", mem_req, 1);
      flush = 1'b1;
      memAck(32'h11111111);
      flush = 1'b0;
      checkOutput("llf_llbit", llbit, 0);
      checkOutput("llf_wb_valid", wb_valid, 0);
      checkOutput("llf_in_ready", in_ready, 1);
      checkOutput("llf_mem_req", mem_req, 0);

      // Flush in IDLE discards the accepted op.
      flush = 1'b1;
      applyStimulus(3'd0, 32'h0, 32'h0, 5'd9, 1'b1, 32'hABCD0000);
      flush = 1'b0;
      checkOutput("flush_idle_wb_valid", wb_valid, 0);

      // Misaligned full-width store.
      applyStimulus(3'd2, 32'h102, 32'h11223344, 5'd0, 1'b0, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
      checkOutput("sw_mis_misalign", misalign, 1);
      checkOutput("sw_mis_mem_req", mem_req, 0);
      checkOutput("sw_mis_wb_valid", wb_valid, 0);
      checkOutput("sw_mis_in_ready", in_ready, 1);
      tick();
      checkOutput("sw_mis_pulse", misalign, 0);
`else
      checkOutput("sw_mem_req", mem_req, 1);
      checkOutput("sw_mem_addr", mem_addr, 32'h100);
      checkOutput("sw_mem_be", mem_be, 4'hF);
      checkOutput("sw_mem_wdata", mem_wdata, 32'h11223344);
      memAck(32'h0);
      checkOutput("sw_wb_valid", wb_valid, 1);
`endif

      // Reset while waiting drops the request.
      applyStimulus(3'd1, 32'h300, 32'h0, 5'd2, 1'b1, 32'h0);
      checkOutput("rstw_mem_req", mem_req, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("rstw_mem_req_drop", mem_req, 0);
      checkOutput("rstw_in_ready", in_ready, 1);
      tick();
      checkOutput("rstw_wb_valid", wb_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
